// File: rtl/hangman_link_pkg.sv
// Shared definitions for the board-to-board letter link, used by both the receiver and the transmitter.
package hangman_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 1042;

  localparam logic [7:0] SUBMIT_WORD = 8'h0D;
  localparam logic [7:0] GAME_END    = 8'h04;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input; 2-cycle latency, reset value set by RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_msg_rx.sv
// 8N1 UART receiver: mid-bit sampling into a holding register with valid/ack; rx_valid rises about 3+(CLKS_PER_BIT-1)/2+9*CLKS_PER_BIT cycles after the start edge.
// The line cannot be stalled: a byte arriving before the previous one is acked overwrites it and sets the sticky overrun flag.
module uart_msg_rx
  import hangman_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;

  logic cnt_run;
  logic cnt_clr;
  logic idx_inc;
  logic idx_clr;
  logic sample_bit;
  logic load;
  logic ferr;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk (clk),
    .nRst(nRst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_run    = 1'b0;
    cnt_clr    = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    sample_bit = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        cnt_run = 1'b1;
        // Re-check the line half a bit in; a high line here was only a glitch.
        if (cnt == HALF_CNT) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (cnt == BIT_CNT) begin
          cnt_clr    = 1'b1;
          sample_bit = 1'b1;
          if (idx == LAST_IDX) begin
            idx_clr   = 1'b1;
            state_nxt = STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      STOP: begin
        cnt_run = 1'b1;
        if (cnt == BIT_CNT) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A break holds the line low; wait it out so it reports only one error.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + 1'b1;
      end

      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 3'd1;
      end

      if (sample_bit) begin
        shift[idx] <= rx_s;
      end

      framing_error <= ferr;

      // A load wins over ack; an ack in the same cycle only suppresses overrun.
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_msg_rx.sv
// Bench for uart_msg_rx at CLKS_PER_BIT=8: vector table, directed corner cases, then random frames against a byte-level model.
module tb_uart_msg_rx;
  import hangman_link_pkg::*;

  localparam int C    = 8;
  localparam int HALF = (C - 1) / 2;
  // Pin-to-rx_valid latency from the start-bit fall, allowed +/-1.
  localparam int LAT_SPEC = 2 + HALF + 9 * C + 1;
  // Edge of the load: two sync flops, one edge leaving IDLE, half a bit, nine bit times.
  localparam int LOAD_EDGE = 4 + HALF + 9 * C;

  logic       tb_clk = 1'b0;
  logic       nRst;
  logic       rx_serial;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  always #5 tb_clk = ~tb_clk;

  uart_msg_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (8)
  ) dut (
    .clk          (tb_clk),
    .nRst         (nRst),
    .rx_serial    (rx_serial),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;
  int ferr_seen = 0;

  always @(negedge tb_clk) begin
    if (framing_error === 1'b1) ferr_seen++;
  end

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  int         m_ferr;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       ack;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ovr;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (C) @(negedge tb_clk);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) begin
      m_ferr++;
    end else begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge tb_clk);
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"}, rx_data, m_data);
    check({tag, "_valid"}, rx_valid, m_valid);
    check({tag, "_ovr"}, overrun, m_ovr);
    check({tag, "_ferr_cnt"}, ferr_seen, m_ferr);
  endtask

  initial begin
    int n;
    int flag;
    logic [7:0] rb;
    logic good;

    nRst = 1'b0;
    rx_serial = 1'b1;
    rx_ack = 1'b0;
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 0;
    repeat (3) @(negedge tb_clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    nRst = 1'b1;
    idle(4);

    vt[0] = '{8'h41, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0};
    vt[1] = '{8'h50, 1'b1, 1'b0, 8'h50, 1'b1, 1'b1};
    vt[2] = '{8'h45, 1'b0, 1'b0, 8'h50, 1'b1, 1'b1};
    vt[3] = '{8'h45, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0};
    vt[4] = '{SUBMIT_WORD, 1'b1, 1'b0, SUBMIT_WORD, 1'b1, 1'b0};
    vt[5] = '{GAME_END, 1'b1, 1'b1, GAME_END, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].b, vt[i].stop);
      model_frame(vt[i].b, vt[i].stop);
      idle(3);
      if (vt[i].ack) ack_pulse();
      check($sformatf("vec%0d_data", i), rx_data, vt[i].e_data);
      check($sformatf("vec%0d_valid", i), rx_valid, vt[i].e_valid);
      check($sformatf("vec%0d_ovr", i), overrun, vt[i].e_ovr);
      check($sformatf("vec%0d_ferr_cnt", i), ferr_seen, m_ferr);
    end

    // 1: single 'A', latency, hold without ack, then ack
    n = 0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        while (rx_valid !== 1'b1 && n < 200) begin
          @(negedge tb_clk);
          n++;
        end
      end
    join
    model_frame(8'h41, 1'b1);
    check("t1_latency_in_window", (n >= LAT_SPEC - 1 && n <= LAT_SPEC + 1) ? 1 : 0, 1);
    rx_serial = 1'b1;
    flag = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge tb_clk);
      if (rx_valid !== 1'b1 || rx_data !== 8'h41) flag = 1;
    end
    check("t1_hold_100", flag, 0);
    ack_pulse();
    check("t1_valid_after_ack", rx_valid, 0);
    check_model("t1");

    // 2: two-cycle glitch
    rx_serial = 1'b0;
    repeat (2) @(negedge tb_clk);
    rx_serial = 1'b1;
    @(negedge tb_clk);
    check("t2_busy_during", busy, 1);
    repeat (5) @(negedge tb_clk);
    check("t2_busy_dropped", busy, 0);
    check_model("t2");

    // 3: bad stop bit followed by a held-low break
    send_frame(8'h50, 1'b0);
    model_frame(8'h50, 1'b0);
    flag = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge tb_clk);
      if (busy !== 1'b1) flag = 1;
    end
    check("t3_busy_in_break", flag, 0);
    idle(4);
    check("t3_busy_after_break", busy, 0);
    check_model("t3_err");
    send_frame(8'h4C, 1'b1);
    model_frame(8'h4C, 1'b1);
    idle(2);
    check_model("t3_next");
    ack_pulse();

    // 4: back-to-back frames without ack
    send_frame(8'h50, 1'b1);
    model_frame(8'h50, 1'b1);
    send_frame(8'h45, 1'b1);
    model_frame(8'h45, 1'b1);
    idle(2);
    check("t4_ovr_set", overrun, 1);
    check_model("t4_ovr");
    ack_pulse();
    check("t4_ovr_clear", overrun, 0);
    check_model("t4_ack");

    // 5: ack lands on the load edge of the second byte
    send_frame(8'h41, 1'b1);
    model_frame(8'h41, 1'b1);
    idle(3);
    fork
      send_frame(8'h4C, 1'b1);
      begin
        repeat (LOAD_EDGE - 1) @(negedge tb_clk);
        check("t5_pre_data", rx_data, 8'h41);
        check("t5_pre_valid", rx_valid, 1);
        rx_ack = 1'b1;
        @(negedge tb_clk);
        rx_ack = 1'b0;
        check("t5_load_data", rx_data, 8'h4C);
        check("t5_load_valid", rx_valid, 1);
        check("t5_load_ovr", overrun, 0);
      end
    join
    m_data = 8'h4C;
    m_valid = 1'b1;
    m_ovr = 1'b0;
    idle(2);
    check_model("t5");

    // 6: reset during data bit 4; bits 4..7 are high so the line idles after reset
    fork
      send_frame(8'hF3, 1'b1);
      begin
        repeat (44) @(negedge tb_clk);
        nRst = 1'b0;
        @(negedge tb_clk);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_ovr", overrun, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ferr", framing_error, 0);
        @(negedge tb_clk);
        nRst = 1'b1;
      end
    join
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    idle(20);
    check_model("t6_abort");
    send_frame(SUBMIT_WORD, 1'b1);
    model_frame(SUBMIT_WORD, 1'b1);
    idle(2);
    check_model("t6_next");
    ack_pulse();

    // Random frames, stop errors, gaps and acks
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_frame(rb, good);
      model_frame(rb, good);
      idle($urandom_range(2, 4));
      if ($urandom_range(0, 1) == 1) ack_pulse();
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_msg_rx.md
Name: uart_msg_rx

Overview:
Serial receiver for the board-to-board letter link. It is the far end of the transmitter that raises msg_sent. It deserialises 8N1 UART frames (one ASCII letter or control byte per frame) into a holding register and presents them to the game FSM with a valid/ack handshake. It also flags framing errors and overruns so the game logic can drive its error LED.

Parameters:
CLKS_PER_BIT, 1042, clk cycles per UART bit (10 MHz / 9600 baud); must be >= 4
DATA_BITS, 8, payload bits per frame, LSB first

Ports:
clk  in  1  system clock, single domain
nRst  in  1  synchronous, active-low reset
rx_serial  in  1  asynchronous serial line, idle high
rx_ack  in  1  consumer accepts rx_data; only meaningful while rx_valid=1
rx_data  out  8  last good received byte
rx_valid  out  1  high from byte load until acknowledged
framing_error  out  1  one-cycle pulse on bad stop bit
overrun  out  1  sticky; a new byte arrived while rx_valid=1 and unacked
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset is synchronous and active-low on the rising edge of clk. While nRst=0 the state is:
  - rx_data=0, rx_valid=0, framing_error=0, overrun=0, busy=0
  - FSM=IDLE, bit counter=0, bit index=0
  - both synchroniser flops=1
- rx_serial passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so pin-to-FSM latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On rx_s=0: go to START and clear the counter.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (integer division).
  - If rx_s=0 at that point: go to DATA and clear the counter.
  - If rx_s=1: treat as a glitch and return to IDLE silently, with no error.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift[index], LSB first.
  - After index DATA_BITS-1: go to STOP. Otherwise increment index and clear the counter.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - If 1: on the next edge, load rx_data=shift and set rx_valid=1, then go to IDLE.
  - If 0: pulse framing_error for exactly 1 cycle, discard the byte (rx_data and rx_valid unchanged), then go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE. A held-low break line produces exactly one framing_error.
- Handshake:
  - rx_ack=1 while rx_valid=1 clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid=0 has no effect.
- Overrun:
  - If a good byte loads while rx_valid=1 and rx_ack=0, the new byte overwrites rx_data, rx_valid stays 1, and overrun is set.
  - If a load and rx_ack occur in the same cycle, the new byte loads, rx_valid stays 1 and overrun=0.
- Latency: rx_valid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the start-bit falling edge at the pin (±1).
- Counter width is $clog2(CLKS_PER_BIT). The bit index is 3 bits and wraps only through reset to 0 on STOP entry.
- Reset mid-frame aborts the frame with no output pulse. The next full frame is received normally.

Decomposition:
- Shared package hangman_link_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - DEFAULT_CLKS_PER_BIT=1042
  - control byte constants shared with the transmitter: SUBMIT_WORD=8'h0D, GAME_END=8'h04
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with reset value parameter RST_VAL=1. The transmitter side reuses it.

Test Plan:
(All scenarios run with CLKS_PER_BIT=8.)
1. Frame 0x41 ('A'), rx_ack held 0 → rx_data=0x41, rx_valid=1 and held for 100 cycles; rx_ack pulse → rx_valid=0 the next cycle; framing_error never asserts.
2. rx_serial low for 2 cycles, then high → FSM returns to IDLE; rx_valid=0, framing_error=0, busy drops within 6 cycles.
3. Frame 0x50 with stop bit=0, line then held low 40 cycles → exactly one framing_error pulse; rx_valid=0; busy stays 1 until the line goes high; a following 0x4C frame gives rx_data=0x4C.
4. Frames 0x50 then 0x45 back-to-back, no ack → rx_data=0x45, rx_valid=1, overrun=1; rx_ack → rx_valid=0 and overrun=0.
5. rx_ack asserted in the exact cycle a second byte 0x4C loads → rx_valid=1, rx_data=0x4C, overrun=0.
6. nRst=0 for 2 cycles during data bit 4 of a frame → all outputs 0, busy=0, no rx_valid for the aborted frame; next frame 0x0D → rx_data=0x0D.
